// File: rtl/score_display_driver.sv
// score_display_driver: clamps two scores, converts them to BCD by double dabble, and scans them onto an 8-digit seven-segment display.
module score_display_driver #(
   parameter int SCAN_DIV  = 50000,
   parameter int MAX_SCORE = 9999
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] left_sc,
   input  logic [31:0] right_sc,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        busy,
   output logic        updated
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2;

   function automatic logic [13:0] clamp(input logic [31:0] v);
      return $signed(v) < 0 ? 14'd0 : (v > 32'(MAX_SCORE) ? 14'(MAX_SCORE) : v[13:0]);
   endfunction

   function automatic logic [15:0] adj(input logic [15:0] b);
      logic [15:0] r;
      r = b;
      for (int i = 0; i < 4; i++)
         r[4*i +: 4] = r[4*i +: 4] >= 4'd5 ? r[4*i +: 4] + 4'd3 : r[4*i +: 4];
      return r;
   endfunction

   function automatic logic [6:0] dec(input logic [3:0] n);
      case (n)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   logic [1:0]    state;
   logic [3:0]    iter;
   logic [13:0]   bin_l, bin_r, cap_l, cap_r, last_l, last_r, cl_l, cl_r;
   logic [15:0]   bcd_l, bcd_r, sc;
   logic [31:0]   dbuf;
   logic [DW-1:0] div;
   logic [2:0]    idx;
   logic [1:0]    pos;
   logic          wrap, blank;

   assign cl_l  = clamp(left_sc);
   assign cl_r  = clamp(right_sc);
   assign busy  = state == SHIFT || state == COMMIT;
   assign wrap  = div == DW'(SCAN_DIV - 1);
   assign sc    = idx[2] ? dbuf[31:16] : dbuf[15:0];
   assign pos   = idx[1:0];
   // a digit is blank when it and every higher digit of the same score are zero
   assign blank = pos == 2'd3 ? sc[15:12] == 4'd0 :
                  pos == 2'd2 ? sc[15:8]  == 8'd0 :
                  pos == 2'd1 ? sc[15:4]  == 12'd0 : 1'b0;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= IDLE;
         iter    <= '0;
         bin_l   <= '0;
         bin_r   <= '0;
         cap_l   <= '0;
         cap_r   <= '0;
         bcd_l   <= '0;
         bcd_r   <= '0;
         last_l  <= '0;
         last_r  <= '0;
         dbuf    <= '0;
         div     <= '0;
         idx     <= '0;
         an      <= 8'hFF;
         seg     <= 7'h7F;
         updated <= 1'b0;
      end else begin
         updated <= state == COMMIT;
         div     <= wrap ? '0 : div + 1'b1;
         idx     <= wrap ? idx + 3'd1 : idx;
         an      <= ~(8'b1 << idx);
         seg     <= blank ? 7'h7F : dec(sc[{pos, 2'b00} +: 4]);
         case (state)
            IDLE: if (cl_l != last_l || cl_r != last_r) begin
               bin_l <= cl_l;
               bin_r <= cl_r;
               cap_l <= cl_l;
               cap_r <= cl_r;
               bcd_l <= '0;
               bcd_r <= '0;
               iter  <= '0;
               state <= SHIFT;
            end
            SHIFT: begin
               {bcd_l, bin_l} <= {adj(bcd_l), bin_l} << 1;
               {bcd_r, bin_r} <= {adj(bcd_r), bin_r} << 1;
               iter  <= iter + 4'd1;
               state <= iter == 4'd13 ? COMMIT : SHIFT;
            end
            COMMIT: begin
               dbuf   <= {bcd_l, bcd_r};
               last_l <= cap_l;
               last_r <= cap_r;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_score_display_driver.sv
// tb_score_display_driver: random and directed scores checked cycle by cycle against a decimal-arithmetic display model.
module tb_score_display_driver;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] left_sc = '0, right_sc = '0;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        busy, updated;
   int n_chk = 0, n_fail = 0;
   int m_last_l, m_last_r, m_disp_l, m_disp_r, m_cap_l, m_cap_r, m_rem, m_k;
   logic m_upd;
   logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   score_display_driver #(.SCAN_DIV(4), .MAX_SCORE(9999)) dut (
      .clock(clock), .reset(reset), .left_sc(left_sc), .right_sc(right_sc),
      .an(an), .seg(seg), .busy(busy), .updated(updated)
   );

   always #5 clock = ~clock;

   function automatic int clampm(input logic [31:0] v);
      int s;
      s = $signed(v);
      return s < 0 ? 0 : (s > 9999 ? 9999 : s);
   endfunction

   function automatic logic [6:0] segm(input int val, input int p);
      return (p > 0 && val < 10 ** p) ? 7'h7F : seg_tbl[(val / (10 ** p)) % 10];
   endfunction

   function automatic logic [31:0] rnd();
      case ($urandom_range(0, 3))
         0: return 32'($urandom_range(0, 9999));
         1: return 32'($urandom_range(0, 99));
         2: return $urandom;
         default: return 32'($urandom_range(9990, 10010));
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      int i, l, r;
      logic [7:0] ea;
      logic [6:0] es;
      i  = (m_k / 4) % 8;
      ea = ~(8'b1 << i);
      es = segm(i < 4 ? m_disp_r : m_disp_l, i % 4);
      l  = clampm(left_sc);
      r  = clampm(right_sc);
      m_upd = 1'b0;
      if (m_rem == 0) begin
         if (l != m_last_l || r != m_last_r) begin
            m_cap_l = l;
            m_cap_r = r;
            m_rem   = 15;
         end
      end else begin
         m_rem--;
         if (m_rem == 0) begin
            m_disp_l = m_cap_l;
            m_disp_r = m_cap_r;
            m_last_l = m_cap_l;
            m_last_r = m_cap_r;
            m_upd    = 1'b1;
         end
      end
      m_k++;
      @(posedge clock);
      #1;
      chk("an", 32'(an), 32'(ea));
      chk("seg", 32'(seg), 32'(es));
      chk("busy", 32'(busy), 32'(m_rem > 0));
      chk("updated", 32'(updated), 32'(m_upd));
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      repeat (n) begin
         @(posedge clock);
         #1;
         chk("rst_an", 32'(an), 32'h0FF);
         chk("rst_seg", 32'(seg), 32'h07F);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_updated", 32'(updated), 32'd0);
      end
      reset = 1'b1;
      m_last_l = 0; m_last_r = 0; m_disp_l = 0; m_disp_r = 0;
      m_cap_l = 0; m_cap_r = 0; m_rem = 0; m_k = 0;
   endtask

   initial begin
      do_reset(3);
      repeat (36) step();
      left_sc = 32'd7; right_sc = 32'd123;
      repeat (40) step();
      left_sc = 32'hFFFFFFFF; right_sc = 32'd20000;
      repeat (40) step();
      right_sc = 32'd5;
      repeat (7) step();
      right_sc = 32'd42;
      repeat (50) step();
      left_sc = 32'd1234; right_sc = 32'd56;
      repeat (8) step();
      do_reset(1);
      repeat (40) step();
      for (int n = 0; n < 30; n++) begin
         left_sc  = rnd();
         right_sc = rnd();
         repeat ($urandom_range(3, 40)) step();
         if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
